// File: rtl/dt_pkg.sv
// Shared distance-transform definitions: FSM states and memory geometry.
// Used by the DT engine, the packer and their testbenches.
package dt_pkg;

    localparam int IMG_SIDE     = 128;
    localparam int PIX_PER_WORD = 16;
    localparam int STI_ADDR_W   = 10;
    localparam int RES_ADDR_W   = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } dt_state_e;

endpackage

// File: rtl/dt_pack_shreg.sv
// 16-bit serial-in/parallel-out packer: bits shift in MSB-first, and the
// load strobe captures the completed word (including the current bit).
module dt_pack_shreg
    import dt_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    shift_en,
    input  logic                    bit_in,
    input  logic                    load,
    output logic [PIX_PER_WORD-1:0] par_out
);

    // Only 15 bits of history are needed; the 16th bit arrives with the load.
    logic [PIX_PER_WORD-2:0] sr_q;
    logic [PIX_PER_WORD-1:0] par_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            par_q <= '0;
        end else begin
            if (shift_en) begin
                sr_q <= {sr_q[PIX_PER_WORD-3:0], bit_in};
            end
            if (shift_en && load) begin
                par_q <= {sr_q, bit_in};
            end
        end
    end

    assign par_out = par_q;

endmodule

// File: rtl/dt_pack.sv
// Thresholds the 128x128 distance result RAM and packs it into 1024x16 STI words.
// Optional frame statistics (max_dist, ones_cnt) are built when DT_PACK_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; only state that accepts start
// READ  | one pixel read, thresholded and shifted per cycle
// FLUSH | write of the final word 1023 in flight
// DONE  | one-cycle done pulse, then back to IDLE
module dt_pack
    import dt_pkg::*;
#(
    parameter int IMG_PIX = 16384,
    parameter int PIX_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PIX_W-1:0]        thr,
    output logic                    busy,
    output logic                    done,
    output logic                    res_rd,
    output logic [RES_ADDR_W-1:0]   res_addr,
    input  logic [PIX_W-1:0]        res_di,
    output logic                    sti_wr,
    output logic [STI_ADDR_W-1:0]   sti_addr,
    output logic [PIX_PER_WORD-1:0] sti_do,
    output logic [PIX_W-1:0]        max_dist,
    output logic [14:0]             ones_cnt
);

    localparam logic [RES_ADDR_W-1:0] LAST_PIX = RES_ADDR_W'(IMG_PIX - 1);

    dt_state_e             state_q, state_d;
    logic [RES_ADDR_W-1:0] pix_cnt_q;
    logic [PIX_W-1:0]      thr_q;
    logic                  sti_wr_q;
    logic [STI_ADDR_W-1:0] sti_addr_q;

    logic start_acc;
    logic rd_en;
    logic pix_bit;
    logic word_end;

    assign start_acc = (state_q == IDLE) && start;
    assign rd_en     = (state_q == READ);
    assign pix_bit   = (res_di >= thr_q);
    assign word_end  = rd_en && (pix_cnt_q[3:0] == 4'hF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (pix_cnt_q == LAST_PIX) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        res_rd = (state_q == READ);
    end

    // pix_cnt wraps to 0 on the last read, which is exactly the FLUSH entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_q  <= '0;
            thr_q      <= '0;
            sti_wr_q   <= 1'b0;
            sti_addr_q <= '0;
        end else begin
            if (start_acc) begin
                thr_q <= thr;
            end
            if (rd_en) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end
            sti_wr_q <= word_end;
            if (word_end) begin
                sti_addr_q <= pix_cnt_q[RES_ADDR_W-1:4];
            end
        end
    end

    dt_pack_shreg u_shreg (
        .clk      (clk),
        .reset    (reset),
        .shift_en (rd_en),
        .bit_in   (pix_bit),
        .load     (word_end),
        .par_out  (sti_do)
    );

    assign res_addr = pix_cnt_q;
    assign sti_wr   = sti_wr_q;
    assign sti_addr = sti_addr_q;

`ifdef DT_PACK_STATS_EN
    logic [PIX_W-1:0] max_q;
    logic [14:0]      ones_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q  <= '0;
            ones_q <= '0;
        end else if (start_acc) begin
            max_q  <= '0;
            ones_q <= '0;
        end else if (rd_en) begin
            if (res_di > max_q) begin
                max_q <= res_di;
            end
            if (pix_bit) begin
                ones_q <= ones_q + 15'd1;
            end
        end
    end

    assign max_dist = max_q;
    assign ones_cnt = ones_q;
`else
    assign max_dist = '0;
    assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_dt_pack.sv
// Directed bench for dt_pack: a RAM model feeds res_di, expected STI writes are
// queued per frame and popped as the DUT writes.
module tb_dt_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thr;
    logic        busy, done, res_rd, sti_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;
    logic [7:0]  max_dist;
    logic [14:0] ones_cnt;

    logic [7:0]  res_mem [0:16383];
    logic [15:0] sti_mem [0:1023];

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wr_cnt      = 0;
    int done_cnt    = 0;
    int done_cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign res_di = res_mem[res_addr];

    dt_pack dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .thr      (thr),
        .busy     (busy),
        .done     (done),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .sti_wr   (sti_wr),
        .sti_addr (sti_addr),
        .sti_do   (sti_do),
        .max_dist (max_dist),
        .ones_cnt (ones_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sti_wr === 1'b1) begin
            wr_cnt++;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("sti_addr", 32'(sti_addr), 32'(e.addr));
                check("sti_do", 32'(sti_do), 32'(e.data));
            end
            sti_mem[sti_addr] = sti_do;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int exp_max;
    int exp_ones;

    task automatic build_expect(input logic [7:0] t);
        logic [15:0] word;
        exp_q.delete();
        exp_max  = 0;
        exp_ones = 0;
        for (int w = 0; w < 1024; w++) begin
            word = 16'h0000;
            for (int b = 0; b < 16; b++) begin
                if (int'(res_mem[w*16+b]) > exp_max) exp_max = int'(res_mem[w*16+b]);
                if (res_mem[w*16+b] >= t) begin
                    word[15-b] = 1'b1;
                    exp_ones++;
                end
            end
            exp_q.push_back('{addr: 10'(w), data: word});
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] t,
                             input int restart_at, input logic [7:0] thr_mid);
        int e_edge;
        int n;
        build_expect(t);
        wr_cnt   = 0;
        done_cnt = 0;
        @(negedge clk);
        thr    = t;
        start  = 1'b1;
        e_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        thr   = thr_mid;
        check({name, "_busy_start"}, 32'(busy), 32'd1);
        check({name, "_rd_start"}, 32'(res_rd), 32'd1);
        n = 1;
        while (done_cnt == 0 && n < 20000) begin
            @(negedge clk);
            n++;
            if (n == restart_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n++;
            end
        end
        check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (5) @(negedge clk);
        check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({name, "_done_cycle"}, 32'(done_cyc), 32'(e_edge + 16385));
        check({name, "_writes"}, 32'(wr_cnt), 32'd1024);
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
`ifdef DT_PACK_STATS_EN
        check({name, "_max_dist"}, 32'(max_dist), 32'(exp_max));
        check({name, "_ones_cnt"}, 32'(ones_cnt), 32'(exp_ones));
`else
        check({name, "_max_dist"}, 32'(max_dist), 32'd0);
        check({name, "_ones_cnt"}, 32'(ones_cnt), 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        thr   = 8'd0;
        for (int i = 0; i < 1024; i++) sti_mem[i] = 16'hDEAD;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res_rd", 32'(res_rd), 32'd0);
        check("rst_sti_wr", 32'(sti_wr), 32'd0);
        check("rst_res_addr", 32'(res_addr), 32'd0);
        check("rst_sti_addr", 32'(sti_addr), 32'd0);
        check("rst_sti_do", 32'(sti_do), 32'd0);
        check("rst_max_dist", 32'(max_dist), 32'd0);
        check("rst_ones_cnt", 32'(ones_cnt), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single hot pixels at the left edge of word 0 and the right edge of word 1.
        for (int i = 0; i < 16384; i++) res_mem[i] = 8'd0;
        res_mem[0]  = 8'd5;
        res_mem[31] = 8'd5;
        run_frame("hot", 8'd5, 0, 8'd5);
        check("hot_word0", 32'(sti_mem[0]), 32'h8000);
        check("hot_word1", 32'(sti_mem[1]), 32'h0001);
        check("hot_word2", 32'(sti_mem[2]), 32'h0000);

        // All 0xFF at thr=255, with a second start ignored mid-frame.
        for (int i = 0; i < 16384; i++) res_mem[i] = 8'hFF;
        run_frame("ff", 8'd255, 100, 8'd255);
        check("ff_word0", 32'(sti_mem[0]), 32'hFFFF);
        check("ff_word1023", 32'(sti_mem[1023]), 32'hFFFF);

        // Reset mid-frame: outputs drop asynchronously.
        for (int i = 0; i < 16384; i++) res_mem[i] = 8'd0;
        build_expect(8'd1);
        @(negedge clk);
        thr   = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5000) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res_rd", 32'(res_rd), 32'd0);
        check("abort_sti_wr", 32'(sti_wr), 32'd0);
        check("abort_res_addr", 32'(res_addr), 32'd0);
        check("abort_sti_do", 32'(sti_do), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Checkerboard after reset; thr changed mid-frame must not matter.
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++)
                res_mem[r*128+c] = 8'((r + c) & 1);
        run_frame("chk", 8'd1, 0, 8'hFF);
        check("chk_row0", 32'(sti_mem[0]), 32'h5555);
        check("chk_row1", 32'(sti_mem[8]), 32'hAAAA);
        check("chk_last", 32'(sti_mem[1023]), 32'hAAAA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
